// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the voice allocator: command layout,
// FSM encoding and status word field offsets.
package synth_voice_pkg;

  localparam int CMD_ON_BIT = 15;
  localparam int NOTE_MSB   = 14;
  localparam int NOTE_LSB   = 8;
  localparam int VEL_MSB    = 7;

  localparam logic [6:0] STOP_ALL_NOTE = 7'h7F;

  localparam int ST_DROP_LSB = 24;
  localparam int ST_LVL_LSB  = 20;
  localparam int ST_BUSY_BIT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_e;

  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [7:0] vel;
  } cmd_t;

  function automatic cmd_t unpack_cmd(input logic [15:0] w);
    cmd_t c;
    c.on   = w[CMD_ON_BIT];
    c.note = w[NOTE_MSB:NOTE_LSB];
    c.vel  = w[VEL_MSB:0];
    return c;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Avalon-MM slave bundle for the voice allocator.
// Ports: write/writedata/read from master, readdata to master.
interface voice_allocator_if;
  logic        avs_s0_write;
  logic [31:0] avs_s0_writedata;
  logic        avs_s0_read;
  logic [31:0] avs_s0_readdata;

  modport master (
    output avs_s0_write, avs_s0_writedata, avs_s0_read,
    input  avs_s0_readdata
  );

  modport slave (
    input  avs_s0_write, avs_s0_writedata, avs_s0_read,
    output avs_s0_readdata
  );
endinterface

// File: rtl/voice_allocator_cmd_fifo.sv
// Synchronous command FIFO (power-of-2 depth).
// Ports: clk, reset, push/din, pop/dout, full, empty, level.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = cnt_q[AW];
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/voice_allocator.sv
// Note command -> voice allocator: FIFO, sequential scan, commit.
// Ports: clk, reset, avs (Avalon slave), per-voice outputs, o_busy.
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int AGE_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  voice_allocator_if.slave          avs,
  output logic [NUM_VOICES-1:0]     o_voice_active,
  output logic [NUM_VOICES*7-1:0]   o_voice_note,
  output logic [NUM_VOICES*8-1:0]   o_voice_vel,
  output logic [NUM_VOICES-1:0]     o_voice_trig,
  output logic                      o_busy
);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  state_e                 state_q, state_d;
  cmd_t                   cmd_q, cmd_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   mok_q, mok_d, fok_q, fok_d, ook_q, ook_d;
  logic [IW-1:0]          mat_q, mat_d, fre_q, fre_d, old_q, old_d;
  logic [AGE_W-1:0]       oage_q, oage_d;
  logic [NUM_VOICES-1:0]  active_q, active_d;
  logic [NUM_VOICES-1:0]  trig_q, trig_d;
  logic [6:0]             note_q [NUM_VOICES];
  logic [6:0]             note_d [NUM_VOICES];
  logic [7:0]             vel_q  [NUM_VOICES];
  logic [7:0]             vel_d  [NUM_VOICES];
  logic [AGE_W-1:0]       age_q  [NUM_VOICES];
  logic [AGE_W-1:0]       age_d  [NUM_VOICES];
  logic [7:0]             drop_q, drop_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [15:0]   fifo_dout;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [LW-1:0] fifo_level;
  logic          busy;
  cmd_t          fcmd;
  logic [IW-1:0] tgt;
  logic          unused_hi;

  assign unused_hi = ^avs.avs_s0_writedata[31:16];

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (avs.avs_s0_write),
    .din   (avs.avs_s0_writedata[15:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign busy = (state_q != IDLE) || !fifo_empty;
  assign fcmd = unpack_cmd(fifo_dout);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    idx_d    = idx_q;
    mok_d    = mok_q;
    fok_d    = fok_q;
    ook_d    = ook_q;
    mat_d    = mat_q;
    fre_d    = fre_q;
    old_d    = old_q;
    oage_d   = oage_q;
    active_d = active_q;
    trig_d   = '0;
    note_d   = note_q;
    vel_d    = vel_q;
    age_d    = age_q;
    drop_d   = drop_q;
    rdata_d  = rdata_q;
    fifo_pop = 1'b0;
    tgt      = '0;

    if (avs.avs_s0_write && fifo_full && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;

    if (avs.avs_s0_read)
      rdata_d = {drop_q, 4'(fifo_level), 3'b000, busy,
                 16'(active_q)};

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fcmd;
          if (!fcmd.on && fcmd.note == STOP_ALL_NOTE) begin
            active_d = '0;
          end else begin
            state_d = SCAN;
            idx_d   = '0;
            mok_d   = 1'b0;
            fok_d   = 1'b0;
            ook_d   = 1'b0;
            oage_d  = '0;
          end
        end
      end
      SCAN: begin
        if (active_q[idx_q] && note_q[idx_q] == cmd_q.note
            && !mok_q) begin
          mok_d = 1'b1;
          mat_d = idx_q;
        end
        if (!active_q[idx_q] && !fok_q) begin
          fok_d = 1'b1;
          fre_d = idx_q;
        end
        // strict > keeps the lowest index on equal ages
        if (active_q[idx_q]
            && (!ook_q || age_q[idx_q] > oage_q)) begin
          ook_d  = 1'b1;
          old_d  = idx_q;
          oage_d = age_q[idx_q];
        end
        if (idx_q == IW'(NUM_VOICES - 1)) state_d = COMMIT;
        else idx_d = idx_q + IW'(1);
      end
      COMMIT: begin
        state_d = IDLE;
        if (cmd_q.on) begin
          tgt = mok_q ? mat_q : (fok_q ? fre_q : old_q);
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_q[i] && IW'(i) != tgt
                && age_q[i] != AGE_MAX)
              age_d[i] = age_q[i] + AGE_W'(1);
          end
          active_d[tgt] = 1'b1;
          note_d[tgt]   = cmd_q.note;
          vel_d[tgt]    = cmd_q.vel;
          age_d[tgt]    = '0;
          trig_d[tgt]   = 1'b1;
        end else if (mok_q) begin
          active_d[mat_q] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      idx_q    <= '0;
      mok_q    <= 1'b0;
      fok_q    <= 1'b0;
      ook_q    <= 1'b0;
      mat_q    <= '0;
      fre_q    <= '0;
      old_q    <= '0;
      oage_q   <= '0;
      active_q <= '0;
      trig_q   <= '0;
      note_q   <= '{default: '0};
      vel_q    <= '{default: '0};
      age_q    <= '{default: '0};
      drop_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      idx_q    <= idx_d;
      mok_q    <= mok_d;
      fok_q    <= fok_d;
      ook_q    <= ook_d;
      mat_q    <= mat_d;
      fre_q    <= fre_d;
      old_q    <= old_d;
      oage_q   <= oage_d;
      active_q <= active_d;
      trig_q   <= trig_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      age_q    <= age_d;
      drop_q   <= drop_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    o_voice_note = '0;
    o_voice_vel  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      o_voice_note[7*i +: 7] = note_q[i];
      o_voice_vel[8*i +: 8]  = vel_q[i];
    end
  end

  assign o_voice_active      = active_q;
  assign o_voice_trig        = trig_q;
  assign o_busy              = busy;
  assign avs.avs_s0_readdata = rdata_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed cases plus
// random command bursts against a behavioural voice-pool model.
module tb_voice_allocator;
  localparam int NV = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  voice_allocator_if bus ();

  logic [NV-1:0]   act;
  logic [NV*7-1:0] notes;
  logic [NV*8-1:0] vels;
  logic [NV-1:0]   trig;
  logic            busy;

  voice_allocator #(
    .NUM_VOICES (NV),
    .FIFO_DEPTH (4),
    .AGE_W      (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .avs            (bus),
    .o_voice_active (act),
    .o_voice_note   (notes),
    .o_voice_vel    (vels),
    .o_voice_trig   (trig),
    .o_busy         (busy)
  );

  int total = 0;
  int bad   = 0;

  // behavioural pool: a voice's age is the number of note-ons
  // since it was last triggered, capped at 255
  bit m_act   [NV];
  int m_note  [NV];
  int m_vel   [NV];
  int m_stamp [NV];
  int m_trig  [NV];
  int m_now;

  int  obs_trig [NV];
  bit  clr;

  always @(negedge clk) begin
    #2;
    for (int i = 0; i < NV; i++) begin
      if (clr) obs_trig[i] = 0;
      else if (trig[i]) obs_trig[i] = obs_trig[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_now = 0;
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_vel[i] = 0;
      m_stamp[i] = 0; m_trig[i] = 0;
    end
  endtask

  task automatic model_apply(input logic [15:0] c);
    int on, n, v, tgt, best, age;
    on = c[15]; n = c[14:8]; v = c[7:0];
    if (on == 0 && n == 127) begin
      for (int i = 0; i < NV; i++) m_act[i] = 0;
      return;
    end
    tgt = -1;
    for (int i = 0; i < NV; i++)
      if (tgt < 0 && m_act[i] && m_note[i] == n) tgt = i;
    if (on == 0) begin
      if (tgt >= 0) m_act[tgt] = 0;
      return;
    end
    for (int i = 0; i < NV; i++)
      if (tgt < 0 && !m_act[i]) tgt = i;
    if (tgt < 0) begin
      best = -1;
      for (int i = 0; i < NV; i++) begin
        age = m_now - m_stamp[i];
        if (age > 255) age = 255;
        if (tgt < 0 || age > best) begin
          tgt = i; best = age;
        end
      end
    end
    m_now++;
    m_act[tgt] = 1; m_note[tgt] = n; m_vel[tgt] = v;
    m_stamp[tgt] = m_now; m_trig[tgt]++;
  endtask

  task automatic compare_all(input string tag);
    @(negedge clk); #3;
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("%s_act%0d", tag, i), 32'(act[i]),
          32'(m_act[i]));
      chk($sformatf("%s_note%0d", tag, i), 32'(notes[7*i +: 7]),
          32'(m_note[i]));
      chk($sformatf("%s_vel%0d", tag, i), 32'(vels[8*i +: 8]),
          32'(m_vel[i]));
      chk($sformatf("%s_trig%0d", tag, i), 32'(obs_trig[i]),
          32'(m_trig[i]));
    end
  endtask

  task automatic do_write(input logic [15:0] c);
    bus.avs_s0_writedata = {16'($urandom), c};
    bus.avs_s0_write = 1'b1;
    model_apply(c);
    @(negedge clk);
    bus.avs_s0_write = 1'b0;
  endtask

  task automatic do_read(output logic [31:0] r);
    bus.avs_s0_read = 1'b1;
    @(negedge clk);
    bus.avs_s0_read = 1'b0;
    r = bus.avs_s0_readdata;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clr = 1'b0;
    model_clear();
  endtask

  task automatic wr_idle(input logic [15:0] c, input string tag);
    do_write(c);
    wait_idle(tag);
  endtask

  initial begin
    logic [31:0] rd;
    logic [15:0] c;
    int n, t0;
    bus.avs_s0_write = 1'b0;
    bus.avs_s0_writedata = '0;
    bus.avs_s0_read = 1'b0;
    reset = 1'b1;
    clr = 1'b1;
    model_clear();
    @(negedge clk);
    do_reset();

    chk("rst_act", 32'(act), 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", bus.avs_s0_readdata, 32'd0);
    chk("rst_note", 32'(notes[31:0]), 32'd0);

    // latency: push edge k, outputs at k+10, trig one cycle
    do_write(16'hDB00);
    repeat (9) @(negedge clk);
    chk("lat_early", 32'(act), 32'd0);
    @(negedge clk);
    chk("lat_act", 32'(act), 32'h01);
    chk("lat_trig", 32'(trig), 32'h01);
    chk("lat_note", 32'(notes[6:0]), 32'd91);
    @(negedge clk);
    chk("lat_trig_off", 32'(trig), 32'd0);
    compare_all("g6");
    do_read(rd);
    chk("rd_g6", rd, 32'h0000_0001);

    wr_idle(16'hBC00, "c4on");
    chk("c4on_mask", 32'(act), 32'h03);
    chk("c4on_note1", 32'(notes[13:7]), 32'd60);
    wr_idle(16'h3C00, "c4off");
    chk("c4off_mask", 32'(act), 32'h01);
    wr_idle(16'h5B00, "g6off");
    chk("g6off_mask", 32'(act), 32'h00);
    compare_all("offs");

    // retrigger
    t0 = obs_trig[0];
    wr_idle(16'hDB00, "rt1");
    wr_idle(16'hDB40, "rt2");
    compare_all("rt");
    chk("rt_mask", 32'(act), 32'h01);
    chk("rt_vel", 32'(vels[7:0]), 32'h40);
    chk("rt_trigs", 32'(obs_trig[0] - t0), 32'd2);

    // steal the oldest
    do_reset();
    for (int i = 0; i < 8; i++)
      wr_idle(16'h8000 | 16'((48 + i) << 8) | 16'(i), "fill");
    wr_idle(16'h9F00, "steal");
    compare_all("steal");
    chk("steal_mask", 32'(act), 32'hFF);
    chk("steal_note0", 32'(notes[6:0]), 32'd31);
    chk("steal_trig0", 32'(obs_trig[0]), 32'd2);

    // overflow: 7 back-to-back writes, 2 dropped
    do_reset();
    for (int i = 0; i < 7; i++) begin
      c = 16'h8000 | 16'((40 + i) << 8) | 16'(i + 1);
      bus.avs_s0_writedata = {16'hA5A5, c};
      bus.avs_s0_write = 1'b1;
      if (i < 5) model_apply(c);
      @(negedge clk);
    end
    bus.avs_s0_write = 1'b0;
    wait_idle("ovf");
    compare_all("ovf");
    do_read(rd);
    chk("ovf_status", rd, 32'h0200_001F);

    // reset in the middle of a scan
    do_write(16'hE07F);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    clr = 1'b1;
    @(negedge clk); #1;
    chk("mid_act", 32'(act), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rdata", bus.avs_s0_readdata, 32'd0);
    chk("mid_note", 32'(notes[34:0]), 32'd0);
    reset = 1'b0;
    clr = 1'b0;
    model_clear();
    repeat (15) @(negedge clk);
    chk("mid_nocommit", 32'(act), 32'd0);
    compare_all("mid");

    // unplayed note-off, then STOP_ALL
    for (int i = 0; i < 4; i++)
      wr_idle(16'h8000 | 16'((64 + i) << 8) | 16'h50, "four");
    wr_idle(16'h4500, "a4off");
    compare_all("a4off");
    chk("a4off_mask", 32'(act), 32'h0F);
    do_write(16'h7F00);
    @(negedge clk);
    chk("stop_mask", 32'(act), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    compare_all("stop");

    // random bursts of up to 4 commands (never overflow)
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 15) == 0) c = 16'h7F00;
        else begin
          c[15]   = ($urandom_range(0, 3) != 0);
          c[14:8] = 7'($urandom_range(60, 71));
          c[7:0]  = 8'($urandom);
        end
        bus.avs_s0_writedata = {16'($urandom), c};
        bus.avs_s0_write = 1'b1;
        model_apply(c);
        @(negedge clk);
      end
      bus.avs_s0_write = 1'b0;
      wait_idle($sformatf("rnd%0d", r));
      compare_all($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
